reg_file_ext: RTL
=================

REG_FILE_EXT -- requirements
Module: reg_file_ext

Interface
REQ-001 SHALL have parameter DW, default 8, data width in bits.
REQ-002 SHALL have parameter AW, default 3, address width; depth = 2**AW entries.
REQ-003 SHALL have parameter BYPASS, default 1; 1 forwards same-cycle write data to matching read ports, 0 reads stored data only.
REQ-004 SHALL have parameter ZERO_R0, default 0; 1 makes entry 0 read as zero and ignore writes.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port wr_en, input, 1, write request.
REQ-008 SHALL have port wr_addr, input, AW, write address.
REQ-009 SHALL have port dat_in, input, DW, write data.
REQ-010 SHALL have port wr_ack, output, 1, high when a write requested this cycle is committed.
REQ-011 SHALL have ports rd_addrA and rd_addrB, input, AW each, read addresses.
REQ-012 SHALL have ports datA_out and datB_out, output, DW each, read data.
REQ-013 SHALL have port clr_req, input, 1, single-cycle pulse starting a background clear sweep.
REQ-014 SHALL have port busy, output, 1, high while the sweep runs.
REQ-015 SHALL have port dirty, output, 2**AW, per-entry flag: written since last reset/clear.

Function
REQ-016 Reads SHALL be combinational, zero latency.
REQ-017 Writes SHALL commit at the rising edge when wr_en=1 and wr_ack=1; wr_ack = wr_en and not busy.
REQ-018 With BYPASS=1, a read address equal to wr_addr during a committing write SHALL return dat_in; otherwise the stored value.
REQ-019 With ZERO_R0=1, reads of entry 0 SHALL return 0, writes to entry 0 SHALL be acked but discarded, and dirty[0] SHALL stay 0.
REQ-020 Committed write to entry n SHALL set dirty[n] at the same edge.
REQ-021 FSM states SHALL be IDLE and SWEEP; IDLE->SWEEP on clr_req=1 while IDLE; SWEEP->IDLE after the edge clearing entry 2**AW-1.
REQ-022 In SWEEP, a sweep counter SHALL start at 0, clear one entry and its dirty bit per cycle, and increment; a full sweep SHALL take exactly 2**AW cycles.
REQ-023 busy SHALL be high exactly while state=SWEEP (cycle after clr_req through last clear cycle).
REQ-024 While busy, wr_ack SHALL be 0 and writes SHALL be dropped; the requester holds wr_en until acked.
REQ-025 clr_req while busy SHALL be ignored; the sweep does not restart.
REQ-026 Reads during SWEEP SHALL return current stored contents (cleared entries read 0, uncleared read old data).
REQ-027 Simultaneous clr_req and wr_en in IDLE SHALL commit the write (wr_ack=1); the sweep then clears it.
REQ-028 The sweep counter SHALL be AW bits and SHALL not wrap past 2**AW-1 within one sweep.

Reset
REQ-029 reset=1 at an edge SHALL zero all entries, zero dirty, zero the sweep counter, and force IDLE, overriding writes and clr_req.
REQ-030 reset during SWEEP SHALL abort the sweep; busy=0 from the next cycle.
REQ-031 After reset: busy=0, dirty=0, datA_out=datB_out=0, wr_ack=wr_en.

Structure
REQ-032 FSM state enum and default DW/AW constants SHALL reside in a shared package rf_pkg.
REQ-033 The block SHALL be a single module with no sub-module; storage is a DW x 2**AW array.

Verification
REQ-034 Reset, write 8'hA5 to r3 (DW=8, AW=3), read A=3 -> datA_out=A5 next cycle, dirty=8'b0000_1000.
REQ-035 BYPASS=1: write 8'h3C to r5 while rd_addrB=5 -> datB_out=3C same cycle; BYPASS=0 -> old value.
REQ-036 Fill r0..r7, pulse clr_req -> busy high 8 cycles; wr_en during sweep -> wr_ack=0, no write; after sweep all reads 0, dirty=0.
REQ-037 Pulse clr_req again at sweep cycle 3 -> busy still ends after 8 cycles total.
REQ-038 reset at sweep cycle 4 -> busy=0 next cycle, all entries 0, IDLE accepts write with wr_ack=1.
REQ-039 ZERO_R0=1: write 8'hFF to r0 -> wr_ack=1, datA_out(0)=0, dirty[0]=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the extended register file: default geometry and sweep FSM states.
package rf_pkg;

    localparam int RF_DW = 8;
    localparam int RF_AW = 3;

    typedef enum logic {
        IDLE,
        SWEEP
    } rf_state_e;

endpackage

// File: rtl/reg_file_ext_if.sv
// Bundles the register-file write, read, clear and status signals for whoever drives the block.
interface reg_file_ext_if
    import rf_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
);
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     dat_in;
    logic              wr_ack;
    logic [AW-1:0]     rd_addrA;
    logic [AW-1:0]     rd_addrB;
    logic [DW-1:0]     datA_out;
    logic [DW-1:0]     datB_out;
    logic              clr_req;
    logic              busy;
    logic [2**AW-1:0]  dirty;

    modport master (
        output wr_en, wr_addr, dat_in, rd_addrA, rd_addrB, clr_req,
        input  wr_ack, datA_out, datB_out, busy, dirty
    );

    modport slave (
        input  wr_en, wr_addr, dat_in, rd_addrA, rd_addrB, clr_req,
        output wr_ack, datA_out, datB_out, busy, dirty
    );
endinterface

// File: rtl/reg_file_ext.sv
// Two-read/one-write register file with optional write bypass, hardwired-zero entry 0,
// per-entry dirty flags and a background clear sweep that blocks writes while it runs.
module reg_file_ext
    import rf_pkg::*;
#(
    parameter int DW      = RF_DW,
    parameter int AW      = RF_AW,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     dat_in,
    output logic              wr_ack,
    input  logic [AW-1:0]     rd_addrA,
    input  logic [AW-1:0]     rd_addrB,
    output logic [DW-1:0]     datA_out,
    output logic [DW-1:0]     datB_out,
    input  logic              clr_req,
    output logic              busy,
    output logic [2**AW-1:0]  dirty
);
    localparam int DEPTH = 2**AW;

    rf_state_e          state_q, state_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    logic [DW-1:0]      mem_q [DEPTH];
    logic [DW-1:0]      mem_d [DEPTH];
    logic [DEPTH-1:0]   dirty_q, dirty_d;
    logic               wr_keep;

    assign busy    = (state_q == SWEEP);
    assign wr_ack  = wr_en && !busy;
    assign dirty   = dirty_q;
    // Writes to a hardwired-zero entry 0 are acknowledged but never stored.
    assign wr_keep = wr_ack && !((ZERO_R0 != 0) && (wr_addr == '0));

    function automatic logic [DW-1:0] read_port(input logic [AW-1:0] addr);
        if ((ZERO_R0 != 0) && (addr == '0))
            return '0;
        else if ((BYPASS != 0) && wr_ack && (addr == wr_addr))
            return dat_in;
        else
            return mem_q[addr];
    endfunction

    assign datA_out = read_port(rd_addrA);
    assign datB_out = read_port(rd_addrB);

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        dirty_d = dirty_q;
        mem_d   = mem_q;
        case (state_q)
            IDLE: begin
                if (wr_keep) begin
                    mem_d[wr_addr]   = dat_in;
                    dirty_d[wr_addr] = 1'b1;
                end
                if (clr_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                mem_d[cnt_q]   = '0;
                dirty_d[cnt_q] = 1'b0;
                // Hold the counter at zero on exit rather than letting it wrap.
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dirty_q <= '0;
            // NOTE: the storage is reset on purpose; reads after reset must return zero.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dirty_q <= dirty_d;
            mem_q   <= mem_d;
        end
    end

endmodule
